// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, stall, flush and bubble gating.
// SKID=1 adds a second entry so in_ready comes straight from a flop.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 2,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic              main_valid, main_valid_n;
    logic              skid_valid, skid_valid_n;
    logic              rdy_q, rdy_n;
    logic [CTRL_W-1:0] main_ctrl, main_ctrl_n, skid_ctrl, skid_ctrl_n;
    logic [DATA_W-1:0] main_data, main_data_n, skid_data, skid_data_n;
    logic              in_fire, out_fire;

    // rdy_q is low during reset; with SKID=0 it only gates the combinational ready.
    assign in_ready  = (SKID != 0) ? rdy_q : (rdy_q & (~main_valid | out_ready));
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = main_valid & out_ready;

    assign out_valid = main_valid;
    assign out_ctrl  = main_valid ? main_ctrl : '0;
    assign out_data  = main_data;
    assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

    always_comb begin
        main_valid_n = main_valid;
        skid_valid_n = skid_valid;
        main_ctrl_n  = main_ctrl;
        main_data_n  = main_data;
        skid_ctrl_n  = skid_ctrl;
        skid_data_n  = skid_data;
        if (flush) begin
            main_valid_n = 1'b0;
            skid_valid_n = 1'b0;
        end else if (SKID != 0) begin
            if (!main_valid) begin
                if (in_fire) begin
                    main_valid_n = 1'b1;
                    main_ctrl_n  = in_ctrl;
                    main_data_n  = in_data;
                end
            end else if (out_fire) begin
                // A full skid entry blocks in_ready, so it never competes with a new beat.
                if (skid_valid) begin
                    main_ctrl_n  = skid_ctrl;
                    main_data_n  = skid_data;
                    skid_valid_n = 1'b0;
                end else if (in_fire) begin
                    main_ctrl_n  = in_ctrl;
                    main_data_n  = in_data;
                end else begin
                    main_valid_n = 1'b0;
                end
            end else if (in_fire) begin
                skid_valid_n = 1'b1;
                skid_ctrl_n  = in_ctrl;
                skid_data_n  = in_data;
            end
        end else begin
            if (in_fire) begin
                main_valid_n = 1'b1;
                main_ctrl_n  = in_ctrl;
                main_data_n  = in_data;
            end else if (out_fire) begin
                main_valid_n = 1'b0;
            end
        end
        rdy_n = (SKID != 0) ? ~skid_valid_n : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            rdy_q      <= 1'b0;
            main_ctrl  <= '0;
            main_data  <= '0;
            skid_ctrl  <= '0;
            skid_data  <= '0;
        end else begin
            main_valid <= main_valid_n;
            skid_valid <= skid_valid_n;
            rdy_q      <= rdy_n;
            main_ctrl  <= main_ctrl_n;
            main_data  <= main_data_n;
            skid_ctrl  <= skid_ctrl_n;
            skid_data  <= skid_data_n;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: one SKID=1 and one SKID=0 instance share stimulus.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rstn, in_valid, flush, out_ready;
    logic [1:0]  in_ctrl;
    logic [31:0] in_data;

    logic        in_ready1, out_valid1, in_ready0, out_valid0;
    logic [1:0]  out_ctrl1, occ1, out_ctrl0, occ0;
    logic [31:0] out_data1, out_data0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(2), .SKID(1)) dut1 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready1),
        .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
        .out_valid(out_valid1), .out_ready(out_ready), .out_ctrl(out_ctrl1),
        .out_data(out_data1), .occupancy(occ1)
    );

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(2), .SKID(0)) dut0 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready0),
        .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
        .out_valid(out_valid0), .out_ready(out_ready), .out_ctrl(out_ctrl0),
        .out_data(out_data0), .occupancy(occ0)
    );

    // Occupancy 3 is illegal for either instance once out of reset.
    always @(negedge clk) begin
        if (rstn === 1'b1) begin
            checks++;
            if (occ1 === 2'd3 || occ0 === 2'd3) begin
                errors++;
                $display("[TB] FAIL occ_legal got %0d/%0d want <3", occ1, occ0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; in_valid = 1'b1; in_data = 32'h55; in_ctrl = 2'b11;
        flush = 1'b0; out_ready = 1'b0;
        tick(); tick();
        settle();
        checks++; if (out_valid1 !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid got %b want 0", out_valid1); end
        checks++; if (out_ctrl1 !== 2'b00) begin errors++; $display("[TB] FAIL rst_ctrl got %b want 00", out_ctrl1); end
        checks++; if (out_data1 !== 32'h0) begin errors++; $display("[TB] FAIL rst_data got %h want 0", out_data1); end
        checks++; if (occ1 !== 2'd0) begin errors++; $display("[TB] FAIL rst_occ got %0d want 0", occ1); end
        checks++; if (in_ready1 !== 1'b0 || in_ready0 !== 1'b0) begin errors++; $display("[TB] FAIL rst_in_ready got %b/%b want 0/0", in_ready1, in_ready0); end
        checks++; if (out_valid0 !== 1'b0 || occ0 !== 2'd0) begin errors++; $display("[TB] FAIL rst_skid0 got %b/%0d want 0/0", out_valid0, occ0); end
        rstn = 1'b1; in_valid = 1'b0;
        tick();
        settle();
        checks++; if (in_ready1 !== 1'b1 || in_ready0 !== 1'b1) begin errors++; $display("[TB] FAIL rel_in_ready got %b/%b want 1/1", in_ready1, in_ready0); end
    endtask

    task automatic test_pass_through();
        logic [31:0] vec [3];
        vec[0] = 32'h100; vec[1] = 32'h104; vec[2] = 32'h108;
        out_ready = 1'b1; in_ctrl = 2'b11;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = vec[i];
            tick();
            checks++; if (out_data1 !== vec[i] || out_valid1 !== 1'b1) begin errors++; $display("[TB] FAIL pass_data%0d got %h/%b want %h/1", i, out_data1, out_valid1, vec[i]); end
            checks++; if (occ1 !== 2'd1 || out_ctrl1 !== 2'b11) begin errors++; $display("[TB] FAIL pass_occ_ctrl%0d got %0d/%b want 1/11", i, occ1, out_ctrl1); end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid1 !== 1'b0 || out_ctrl1 !== 2'b00 || occ1 !== 2'd0) begin errors++; $display("[TB] FAIL pass_drain got %b/%b/%0d want 0/00/0", out_valid1, out_ctrl1, occ1); end
        checks++; if (out_data1 !== 32'h108) begin errors++; $display("[TB] FAIL pass_hold got %h want 108", out_data1); end
    endtask

    task automatic test_stall_skid();
        out_ready = 1'b0; in_ctrl = 2'b01; in_valid = 1'b1; in_data = 32'hA;
        tick();
        settle();
        checks++; if (occ1 !== 2'd1 || in_ready1 !== 1'b1) begin errors++; $display("[TB] FAIL stall_one got %0d/%b want 1/1", occ1, in_ready1); end
        in_data = 32'hB;
        tick();
        in_data = 32'hEE;
        settle();
        checks++; if (occ1 !== 2'd2 || in_ready1 !== 1'b0) begin errors++; $display("[TB] FAIL stall_full got %0d/%b want 2/0", occ1, in_ready1); end
        tick();
        checks++; if (occ1 !== 2'd2 || out_data1 !== 32'hA || out_ctrl1 !== 2'b01) begin errors++; $display("[TB] FAIL stall_hold got %0d/%h/%b want 2/a/01", occ1, out_data1, out_ctrl1); end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        checks++; if (out_data1 !== 32'hB || occ1 !== 2'd1 || in_ready1 !== 1'b1) begin errors++; $display("[TB] FAIL skid_move got %h/%0d/%b want b/1/1", out_data1, occ1, in_ready1); end
        tick();
        checks++; if (out_valid1 !== 1'b0 || occ1 !== 2'd0) begin errors++; $display("[TB] FAIL skid_empty got %b/%0d want 0/0", out_valid1, occ1); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_ctrl = 2'b11; in_valid = 1'b1; in_data = 32'h1;
        tick();
        in_data = 32'h2;
        tick();
        checks++; if (occ1 !== 2'd2) begin errors++; $display("[TB] FAIL flush_fill got %0d want 2", occ1); end
        flush = 1'b1; in_data = 32'hC;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        settle();
        checks++; if (out_valid1 !== 1'b0 || out_ctrl1 !== 2'b00 || occ1 !== 2'd0) begin errors++; $display("[TB] FAIL flush_clear got %b/%b/%0d want 0/00/0", out_valid1, out_ctrl1, occ1); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (out_valid1 !== 1'b0 || out_data1 === 32'hC) begin errors++; $display("[TB] FAIL flush_no_c got %b/%h want 0/not c", out_valid1, out_data1); end
        end
    endtask

    task automatic test_no_skid();
        in_valid = 1'b1; in_ctrl = 2'b10; out_ready = 1'b1; in_data = 32'h20;
        settle();
        checks++; if (in_ready0 !== 1'b1) begin errors++; $display("[TB] FAIL ns_rdy0 got %b want 1", in_ready0); end
        tick();
        checks++; if (out_valid0 !== 1'b1 || out_data0 !== 32'h20 || occ0 !== 2'd1) begin errors++; $display("[TB] FAIL ns_first got %b/%h/%0d want 1/20/1", out_valid0, out_data0, occ0); end
        out_ready = 1'b0; in_data = 32'h21;
        settle();
        checks++; if (in_ready0 !== 1'b0) begin errors++; $display("[TB] FAIL ns_rdy1 got %b want 0", in_ready0); end
        tick();
        checks++; if (out_data0 !== 32'h20 || out_ctrl0 !== 2'b10) begin errors++; $display("[TB] FAIL ns_stall got %h/%b want 20/10", out_data0, out_ctrl0); end
        out_ready = 1'b1;
        settle();
        checks++; if (in_ready0 !== 1'b1) begin errors++; $display("[TB] FAIL ns_rdy2 got %b want 1", in_ready0); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_data0 !== 32'h21 || out_valid0 !== 1'b1) begin errors++; $display("[TB] FAIL ns_replace got %h/%b want 21/1", out_data0, out_valid0); end
        tick();
        checks++; if (out_valid0 !== 1'b0 || out_ctrl0 !== 2'b00) begin errors++; $display("[TB] FAIL ns_drain got %b/%b want 0/00", out_valid0, out_ctrl0); end
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0; in_ctrl = 2'b11; in_valid = 1'b1; in_data = 32'h31;
        tick();
        in_data = 32'h32;
        tick();
        checks++; if (occ1 !== 2'd2) begin errors++; $display("[TB] FAIL mr_fill got %0d want 2", occ1); end
        rstn = 1'b0; in_valid = 1'b0;
        tick();
        rstn = 1'b1;
        settle();
        checks++; if (out_valid1 !== 1'b0 || out_ctrl1 !== 2'b00 || occ1 !== 2'd0 || out_data1 !== 32'h0) begin errors++; $display("[TB] FAIL mr_state got %b/%b/%0d/%h want 0/00/0/0", out_valid1, out_ctrl1, occ1, out_data1); end
        checks++; if (in_ready1 !== 1'b0 || out_data0 !== 32'h0) begin errors++; $display("[TB] FAIL mr_ready got %b/%h want 0/0", in_ready1, out_data0); end
        tick();
        checks++; if (in_ready1 !== 1'b1) begin errors++; $display("[TB] FAIL mr_release got %b want 1", in_ready1); end
        out_ready = 1'b1; in_valid = 1'b1; in_ctrl = 2'b10; in_data = 32'hD;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid1 !== 1'b1 || out_data1 !== 32'hD || out_ctrl1 !== 2'b10) begin errors++; $display("[TB] FAIL mr_beat got %b/%h/%b want 1/d/10", out_valid1, out_data1, out_ctrl1); end
        tick();
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_stall_skid();
        test_flush();
        test_no_skid();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
